// File: rtl/demux8_collector_pkg.sv
// Shared types and defaults for the demux8_collector frame collector.
package demux_pkg;
    typedef enum logic {FILL, HOLD} collector_state_t;
    localparam int DEMUX_DEFAULT_WIDTH = 8;
endpackage

// File: rtl/demux8_collector_if.sv
// Bit-input / vector-output handshake bundle for demux8_collector.
// Carries dup_err only when DEMUX8_COLLECTOR_DUP_ERR_EN is defined.
interface demux8_collector_if #(
    parameter int WIDTH = 8
) ();
    localparam int SEL_W = $clog2(WIDTH);

    logic             in_bit;
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] sel;
    logic             auto_inc;
    logic             clear;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] written;
    logic             out_valid;
    logic             out_ready;
`ifdef DEMUX8_COLLECTOR_DUP_ERR_EN
    logic             dup_err;
`endif

    modport master (
        output in_bit, in_valid, sel, auto_inc, clear, out_ready,
`ifdef DEMUX8_COLLECTOR_DUP_ERR_EN
        input  dup_err,
`endif
        input  in_ready, out, written, out_valid
    );

    modport slave (
        input  in_bit, in_valid, sel, auto_inc, clear, out_ready,
`ifdef DEMUX8_COLLECTOR_DUP_ERR_EN
        output dup_err,
`endif
        output in_ready, out, written, out_valid
    );
endinterface

// File: rtl/demux8_collector_dec_onehot.sv
// Select-to-one-hot decoder with enable; all strobes low when en_i is low.
module dec_onehot #(
    parameter int SEL_W = 3,
    parameter int WIDTH = 8
) (
    input  logic [SEL_W-1:0] idx_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] onehot_o
);
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
        assign onehot_o[gi] = en_i && (idx_i == SEL_W'(gi));
    end
endmodule

// File: rtl/demux8_collector.sv
// Registered 1:WIDTH bit demultiplexer that collects a full frame and presents it
// with a valid/ready handshake. Define DEMUX8_COLLECTOR_DUP_ERR_EN for dup_err.
module demux8_collector
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_DEFAULT_WIDTH,
    localparam int SEL_W = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                reset_n,
    demux8_collector_if.slave   bus
);
    collector_state_t state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d, idx;
    logic [WIDTH-1:0] out_q, out_d, written_q, written_d, wr_stb;
    logic             accept;

    assign accept = bus.in_valid && (state_q == FILL);
    assign idx    = bus.auto_inc ? ptr_q : bus.sel;

    dec_onehot #(.SEL_W(SEL_W), .WIDTH(WIDTH)) u_dec (
        .idx_i    (idx),
        .en_i     (accept),
        .onehot_o (wr_stb)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        out_d     = out_q;
        written_d = written_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    out_d     = (out_q & ~wr_stb) | (wr_stb & {WIDTH{bus.in_bit}});
                    written_d = written_q | wr_stb;
                    if (bus.auto_inc) begin
                        ptr_d = ptr_q + 1'b1;
                    end
                    if (&written_d) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // out is left alone so old bits persist until overwritten
                if (bus.out_ready) begin
                    written_d = '0;
                    ptr_d     = '0;
                    state_d   = FILL;
                end
            end
            default: state_d = FILL;
        endcase
        if (bus.clear) begin
            state_d   = FILL;
            ptr_d     = '0;
            out_d     = '0;
            written_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= FILL;
            ptr_q     <= '0;
            out_q     <= '0;
            written_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            out_q     <= out_d;
            written_q <= written_d;
        end
    end

    assign bus.in_ready  = (state_q == FILL);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out       = out_q;
    assign bus.written   = written_q;

`ifdef DEMUX8_COLLECTOR_DUP_ERR_EN
    logic dup_q, dup_d;

    always_comb begin
        dup_d = dup_q | (|(wr_stb & written_q));
        if (bus.clear || (state_q == HOLD && bus.out_ready)) begin
            dup_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dup_q <= 1'b0;
        end else begin
            dup_q <= dup_d;
        end
    end

    assign bus.dup_err = dup_q;
`endif
endmodule

// File: tb/tb_demux8_collector.sv
// Scenario bench for demux8_collector: expected frames are queued when driven
// and checked by a monitor when the consumer takes them.
module tb_demux8_collector;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    demux8_collector_if #(.WIDTH(8)) bus ();

    demux8_collector #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Scoreboard monitor: a frame leaves on the edge following a negedge with valid & ready.
    always @(negedge clk) begin
        if (reset_n && bus.out_valid && bus.out_ready) begin
            logic [7:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: out=%h with empty queue", bus.out);
            end else begin
                e = exp_q.pop_front();
                if (bus.out !== e) begin
                    errors++;
                    $display("FAIL sb_frame: out=%h expected %h", bus.out, e);
                end else begin
                    $display("frame out=%h ok", bus.out);
                end
                checks++;
                if (bus.written !== 8'hFF) begin
                    errors++;
                    $display("FAIL sb_written: written=%h expected ff", bus.written);
                end
            end
        end
    end

    task automatic accept_bit(input logic b, input logic ai, input logic [2:0] s);
        bus.in_bit   = b;
        bus.auto_inc = ai;
        bus.sel      = s;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        $display("drive bit=%0d auto=%0d sel=%0d -> written=%h out=%h ov=%0d",
                 b, ai, s, bus.written, bus.out, bus.out_valid);
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.out !== 8'h00 || bus.written !== 8'h00) begin
            errors++;
            $display("FAIL reset: ov=%b ir=%b out=%h wr=%h expected 0 1 00 00",
                     bus.out_valid, bus.in_ready, bus.out, bus.written);
        end
`ifdef DEMUX8_COLLECTOR_DUP_ERR_EN
        checks++;
        if (bus.dup_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_dup: dup_err=%b expected 0", bus.dup_err);
        end
`endif
    endtask

    task automatic test_auto_frame();
        logic [7:0] v = 8'hCA;
        exp_q.push_back(v);
        for (int i = 0; i < 8; i++) begin
            accept_bit(v[i], 1'b1, 3'd0);
            checks++;
            if (bus.out_valid !== (i == 7)) begin
                errors++;
                $display("FAIL auto_ov: accept %0d out_valid=%b expected %b", i, bus.out_valid, i == 7);
            end
        end
        checks++;
        if (bus.out !== 8'hCA || bus.written !== 8'hFF || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL auto_frame: out=%h wr=%h ir=%b expected ca ff 0", bus.out, bus.written, bus.in_ready);
        end
        handshake();
    endtask

    task automatic test_select_reverse();
        logic [7:0] v = 8'h35;
        logic [7:0] z = 8'h00;
        exp_q.push_back(v);
        for (int i = 7; i >= 0; i--) begin
            accept_bit(v[i], 1'b0, 3'(i));
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== 8'h35) begin
            errors++;
            $display("FAIL sel_frame: ov=%b out=%h expected 1 35", bus.out_valid, bus.out);
        end
        handshake();
        // pointer must still be 0: the first auto accept lands in lane 0
        accept_bit(1'b0, 1'b1, 3'd5);
        checks++;
        if (bus.written !== 8'h01 || bus.out !== 8'h34) begin
            errors++;
            $display("FAIL sel_ptr: wr=%h out=%h expected 01 34", bus.written, bus.out);
        end
        exp_q.push_back(z);
        for (int i = 1; i < 8; i++) accept_bit(z[i], 1'b1, 3'd0);
        handshake();
    endtask

    task automatic test_backpressure();
        logic [7:0] v = 8'h5A;
        exp_q.push_back(v);
        for (int i = 0; i < 8; i++) accept_bit(v[i], 1'b1, 3'd0);
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.out !== 8'h5A || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold: cyc %0d out=%h ir=%b ov=%b expected 5a 0 1",
                         c, bus.out, bus.in_ready, bus.out_valid);
            end
        end
        bus.in_valid = 1'b0;
        handshake();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.written !== 8'h00) begin
            errors++;
            $display("FAIL bp_release: ov=%b ir=%b wr=%h expected 0 1 00",
                     bus.out_valid, bus.in_ready, bus.written);
        end
    endtask

    task automatic test_duplicate();
        logic [2:0] lanes[7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
        exp_q.push_back(8'hF7);
        accept_bit(1'b1, 1'b0, 3'd3);
`ifdef DEMUX8_COLLECTOR_DUP_ERR_EN
        checks++;
        if (bus.dup_err !== 1'b0) begin
            errors++;
            $display("FAIL dup_first: dup_err=%b expected 0", bus.dup_err);
        end
`endif
        accept_bit(1'b0, 1'b0, 3'd3);
        checks++;
        if (bus.written !== 8'h08 || bus.out[3] !== 1'b0) begin
            errors++;
            $display("FAIL dup_over: wr=%h out3=%b expected 08 0", bus.written, bus.out[3]);
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL dup_early: ov=%b expected 0 before lane %0d", bus.out_valid, lanes[i]);
            end
`ifdef DEMUX8_COLLECTOR_DUP_ERR_EN
            checks++;
            if (bus.dup_err !== 1'b1) begin
                errors++;
                $display("FAIL dup_sticky: dup_err=%b expected 1", bus.dup_err);
            end
`endif
            accept_bit(1'b1, 1'b0, lanes[i]);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== 8'hF7) begin
            errors++;
            $display("FAIL dup_frame: ov=%b out=%h expected 1 f7", bus.out_valid, bus.out);
        end
        handshake();
`ifdef DEMUX8_COLLECTOR_DUP_ERR_EN
        checks++;
        if (bus.dup_err !== 1'b0) begin
            errors++;
            $display("FAIL dup_cleared: dup_err=%b expected 0", bus.dup_err);
        end
`endif
    endtask

    task automatic test_clear();
        logic [7:0] v = 8'h81;
        for (int i = 0; i < 4; i++) accept_bit(1'b1, 1'b1, 3'd0);
        bus.clear = 1'b1;
        accept_bit(1'b1, 1'b1, 3'd0);
        bus.clear = 1'b0;
        checks++;
        if (bus.written !== 8'h00 || bus.out !== 8'h00 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear: wr=%h out=%h ir=%b expected 00 00 1", bus.written, bus.out, bus.in_ready);
        end
        exp_q.push_back(v);
        accept_bit(v[0], 1'b1, 3'd0);
        checks++;
        if (bus.written !== 8'h01) begin
            errors++;
            $display("FAIL clear_ptr: wr=%h expected 01", bus.written);
        end
        for (int i = 1; i < 8; i++) accept_bit(v[i], 1'b1, 3'd0);
        handshake();
    endtask

    task automatic test_reset_in_hold();
        for (int i = 0; i < 8; i++) accept_bit(1'b1, 1'b1, 3'd0);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_hold_pre: ov=%b expected 1", bus.out_valid);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out !== 8'h00 || bus.written !== 8'h00) begin
            errors++;
            $display("FAIL rst_async: ov=%b out=%h wr=%h expected 0 00 00",
                     bus.out_valid, bus.out, bus.written);
        end
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready: ir=%b expected 1", bus.in_ready);
        end
        accept_bit(1'b1, 1'b1, 3'd6);
        checks++;
        if (bus.written !== 8'h01 || bus.out !== 8'h01) begin
            errors++;
            $display("FAIL rst_lane0: wr=%h out=%h expected 01 01", bus.written, bus.out);
        end
    endtask

    initial begin
        bus.in_bit    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.sel       = '0;
        bus.auto_inc  = 1'b1;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        test_reset();
        #11 reset_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_auto_frame();
        test_select_reverse();
        test_backpressure();
        test_duplicate();
        test_clear();
        test_reset_in_hold();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d frames never delivered, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
